// File: rtl/conv_sequencer.sv
// Control sequencer for the tiled binary convolution datapath: steps each 4x4 tile
// through read, XNOR, popcount, output and write phases, and reports run progress.
module conv_sequencer #(
    parameter int NUM_TILES = 16,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic [2:0]  cState,
    output logic        dut_busy,
    output logic [11:0] tile_index,
    output logic        run_done
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'b000,
        ST_READMEM  = 3'b001,
        ST_XNORS    = 3'b011,
        ST_COUNT1S  = 3'b010,
        ST_OUTPUTS  = 3'b110,
        ST_WRITEMEM = 3'b111,
        ST_DONE     = 3'b101,
        ST_SYSRESET = 3'b100
    } state_t;

    localparam logic [11:0] LAST_TILE = 12'(NUM_TILES - 1);
    localparam logic [1:0]  WAIT_MAX  = 2'(READ_LAT);

    state_t     state;
    logic [1:0] wait_cnt;

    // The state code itself is the datapath control word, so it leaves the flop untouched.
    assign cState = state;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= ST_SYSRESET;
            dut_busy   <= 1'b0;
            tile_index <= 12'd0;
            run_done   <= 1'b0;
            wait_cnt   <= 2'd0;
        end else begin
            run_done <= 1'b0;
            case (state)
                ST_SYSRESET: begin
                    state    <= ST_WAIT;
                    dut_busy <= 1'b0;
                end
                ST_WAIT: begin
                    if (dut_run) begin
                        state    <= ST_READMEM;
                        wait_cnt <= 2'd0;
                        dut_busy <= 1'b1;
                    end
                end
                ST_READMEM: begin
                    // Stretch the read phase so SRAM/WMEM data is valid before XNORS.
                    if (wait_cnt == WAIT_MAX) begin
                        state <= ST_XNORS;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_XNORS:    state <= ST_COUNT1S;
                ST_COUNT1S:  state <= ST_OUTPUTS;
                ST_OUTPUTS:  state <= ST_WRITEMEM;
                ST_WRITEMEM: state <= ST_DONE;
                ST_DONE: begin
                    if (tile_index < LAST_TILE) begin
                        tile_index <= tile_index + 12'd1;
                        wait_cnt   <= 2'd0;
                        state      <= ST_READMEM;
                    end else begin
                        tile_index <= 12'd0;
                        run_done   <= 1'b1;
                        dut_busy   <= 1'b0;
                        state      <= ST_SYSRESET;
                    end
                end
                default: begin
                    state    <= ST_SYSRESET;
                    dut_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench: three sequencer configurations share one stimulus stream and are
// compared every cycle against a run-position model of the tile schedule.
module tb_conv_sequencer;

    typedef struct packed {
        logic [2:0]  st;
        logic        busy;
        logic [11:0] tile;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        dut_run;
    logic [2:0]  cst  [3];
    logic        busy [3];
    logic [11:0] tile [3];
    logic        done [3];

    always #5 clk = ~clk;

    conv_sequencer #(.NUM_TILES(16), .READ_LAT(1)) u_dut0 (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run),
        .cState(cst[0]), .dut_busy(busy[0]), .tile_index(tile[0]), .run_done(done[0]));
    conv_sequencer #(.NUM_TILES(4), .READ_LAT(0)) u_dut1 (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run),
        .cState(cst[1]), .dut_busy(busy[1]), .tile_index(tile[1]), .run_done(done[1]));
    conv_sequencer #(.NUM_TILES(1), .READ_LAT(3)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run),
        .cState(cst[2]), .dut_busy(busy[2]), .tile_index(tile[2]), .run_done(done[2]));

    function automatic int nt_of(int g);
        case (g)
            0: return 16;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int rl_of(int g);
        case (g)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    // Model: mode 0 = in/after reset, 1 = idle, 2 = running (k cycles since run start),
    // 3 = the single post-run cycle carrying run_done.
    int   mode [3];
    int   k    [3];
    exp_t q    [3][$];

    function automatic exp_t expect_of(int g);
        exp_t e;
        int p, off;
        e = '{st: 3'b100, busy: 1'b0, tile: 12'd0, done: 1'b0};
        case (mode[g])
            1: e.st = 3'b000;
            2: begin
                p      = rl_of(g) + 6;
                off    = k[g] % p;
                e.busy = 1'b1;
                e.tile = 12'(k[g] / p);
                if (off <= rl_of(g)) e.st = 3'b001;
                else begin
                    case (off - rl_of(g))
                        1: e.st = 3'b011;
                        2: e.st = 3'b010;
                        3: e.st = 3'b110;
                        4: e.st = 3'b111;
                        default: e.st = 3'b101;
                    endcase
                end
            end
            3: e.done = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!reset_b) begin
                mode[g] = 0;
                k[g]    = 0;
            end else begin
                case (mode[g])
                    0, 3: mode[g] = 1;
                    1: if (dut_run) begin
                        mode[g] = 2;
                        k[g]    = 0;
                    end
                    default: begin
                        k[g] = k[g] + 1;
                        if (k[g] == nt_of(g) * (rl_of(g) + 6)) mode[g] = 3;
                    end
                endcase
            end
            q[g].push_back(expect_of(g));
        end
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    int   async_tok = 0;
    int   async_seen = 0;
    logic timeout_hit = 1'b0;
    exp_t m_exp, m_act;

    always @(negedge clk or async_tok) begin
        if (async_tok != async_seen) begin
            async_seen = async_tok;
            n_cmp++;
            if (timeout_hit !== 1'b0) begin
                n_bad++;
                $display("FAIL find_tile5_count1s: got timeout=%b, want 0", timeout_hit);
            end
            for (int g = 0; g < 3; g++) begin
                m_act = {cst[g], busy[g], tile[g], done[g]};
                m_exp = '{st: 3'b100, busy: 1'b0, tile: 12'd0, done: 1'b0};
                n_cmp++;
                if (m_act !== m_exp) begin
                    n_bad++;
                    $display("FAIL async_reset_dut%0d: got st=%b busy=%b tile=%0d done=%b, want st=%b busy=%b tile=%0d done=%b",
                             g, m_act.st, m_act.busy, m_act.tile, m_act.done,
                             m_exp.st, m_exp.busy, m_exp.tile, m_exp.done);
                end
            end
        end else if (clk == 1'b0) begin
            for (int g = 0; g < 3; g++) begin
                if (q[g].size() > 0) begin
                    m_exp = q[g].pop_front();
                    m_act = {cst[g], busy[g], tile[g], done[g]};
                    n_cmp++;
                    if (m_act !== m_exp) begin
                        n_bad++;
                        $display("FAIL cycle_dut%0d @%0t: got st=%b busy=%b tile=%0d done=%b, want st=%b busy=%b tile=%0d done=%b",
                                 g, $time, m_act.st, m_act.busy, m_act.tile, m_act.done,
                                 m_exp.st, m_exp.busy, m_exp.tile, m_exp.done);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset_b = 1'b1;
        dut_run = 1'b0;
        #2 reset_b = 1'b0;
        cycles(3);
        reset_b = 1'b1;
        cycles(10);

        // Single-pulse run: 112 / 24 / 9 busy cycles for the three configurations.
        dut_run = 1'b1;
        cycles(1);
        dut_run = 1'b0;
        cycles(130);

        for (int i = 0; i < 400; i++) begin
            dut_run = ($urandom_range(0, 3) == 0);
            cycles(1);
        end

        dut_run = 1'b1;
        cycles(300);
        dut_run = 1'b0;
        cycles(250);

        // Abandon a run from COUNT1S of tile 5 with a mid-cycle reset.
        dut_run = 1'b1;
        cycles(1);
        dut_run = 1'b0;
        timeout_hit = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (cst[0] == 3'b010 && tile[0] == 12'd5) begin
                timeout_hit = 1'b0;
                break;
            end
        end
        reset_b = 1'b0;
        #1;
        async_tok++;
        @(negedge clk);
        #1;
        cycles(1);
        reset_b = 1'b1;
        cycles(20);

        dut_run = 1'b1;
        cycles(1);
        dut_run = 1'b0;
        cycles(130);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
